// File: rtl/instruction_loader_pkg.sv
// Purpose: shared types and defaults for the MIPS instruction loader (FSM encoding, word geometry, halt marker).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_loader_pkg;

    // Default instruction word width and instruction memory depth (2^11 = 2048 words).
    localparam int LEN_DEF    = 32;
    localparam int ADDR_W_DEF = 11;

    // End-of-program marker; a program is complete once this word has been written.
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Width of one received serial byte.
    localparam int BYTE_W = 8;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } load_state_t;

    // Number of received bytes that make up one instruction word.
    function automatic int bytes_per_word(input int len);
        return len / BYTE_W;
    endfunction

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Purpose: assembles big-endian bytes into instruction words (first byte lands in the MSBs).
// Latency: word strobe and data are registered, one cycle after the last byte of a word is accepted.
// Backpressure: none; every byte strobe is accepted, the caller gates the strobe when it must not count.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   clear               drop any partially assembled word and restart at byte 0
//   byte_vld/byte_dat   byte-in strobe and data
//   word_last           combinational: the byte presented now completes a word
//   word_next           combinational: word as it would be with the byte presented now
//   word_vld/word_dat   registered word-out strobe (one cycle) and assembled word
module byte_packer
    import instruction_loader_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           byte_vld,
    input  logic [7:0]     byte_dat,
    output logic           word_last,
    output logic [LEN-1:0] word_next,
    output logic           word_vld,
    output logic [LEN-1:0] word_dat
);

    localparam int NBYTES = bytes_per_word(LEN);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [IDX_W-1:0] byte_idx;
    logic [LEN-1:0]   shift_q;

    // Shifting left means the oldest byte of the word ends up in the MSBs once
    // all NBYTES bytes are in. Stale bits from the previous word are fully
    // shifted out by then, so the shifter never needs clearing between words.
    assign word_next = {shift_q[LEN-BYTE_W-1:0], byte_dat};
    assign word_last = byte_vld && (byte_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= '0;
            shift_q  <= '0;
            word_vld <= 1'b0;
            word_dat <= '0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
                shift_q  <= '0;
            end else if (byte_vld) begin
                shift_q <= word_next;
                if (word_last) begin
                    // Index wraps here, so a byte arriving while word_vld is
                    // high is taken as byte 0 of the following word.
                    byte_idx <= '0;
                    word_vld <= 1'b1;
                    word_dat <= word_next;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Purpose: loads a program received as a byte stream into instruction memory, stopping at the halt word.
// Latency: memory write strobe one cycle after the last byte of each word; status flags change on that same cycle.
// Backpressure: none; bytes are consumed as they arrive, o_loading stalls the fetch stage while a load runs.
//
// Ports:
//   i_clk, i_rst         clock and synchronous active-low reset
//   i_start              one-cycle pulse starting a load (ignored while a load is running)
//   i_rx_data/i_rx_valid received byte and its single-cycle strobe
//   o_wr_addr/o_wr_data  instruction memory word address and data
//   o_wr_en              one-cycle write strobe per word
//   o_loading            load in progress
//   o_done               halt word written, program complete
//   o_overflow           memory filled without seeing the halt word
//   o_word_count         words written during the current load
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int             LEN       = LEN_DEF,
    parameter int             ADDR_W    = ADDR_W_DEF,
    parameter logic [LEN-1:0] HALT_WORD = LEN'(HALT_WORD_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [LEN-1:0]    o_wr_data,
    output logic              o_wr_en,
    output logic              o_loading,
    output logic              o_done,
    output logic              o_overflow,
    output logic [ADDR_W:0]   o_word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    load_state_t       state;
    load_state_t       state_nxt;

    logic              start_load;
    logic              byte_vld;
    logic              word_last;
    logic [LEN-1:0]    word_next;
    logic              word_vld;
    logic [LEN-1:0]    word_dat;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] word_idx;
    logic              is_halt;
    logic              at_last_addr;

    // A start pulse only matters outside RECV; a running load ignores it.
    assign start_load = i_start && (state != ST_RECV);

    // Bytes count only while receiving. In IDLE/DONE/ERROR they are dropped,
    // including one that coincides with the start pulse.
    assign byte_vld = i_rx_valid && (state == ST_RECV);

    // The word index is the low part of the written-word count: the next
    // word always goes to the address equal to the number already written.
    assign word_idx     = word_count[ADDR_W-1:0];
    assign at_last_addr = (word_idx == LAST_ADDR);

    // Decided on the byte that completes the word, so the FSM leaves RECV on
    // the same edge that raises the write strobe for that word.
    assign is_halt = (word_next == HALT_WORD);

    byte_packer #(
        .LEN (LEN)
    ) u_byte_packer (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .clear     (start_load),
        .byte_vld  (byte_vld),
        .byte_dat  (i_rx_data),
        .word_last (word_last),
        .word_next (word_next),
        .word_vld  (word_vld),
        .word_dat  (word_dat)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (word_last) begin
                    // The halt word wins even when it lands on the last
                    // address: a program that exactly fills memory is valid.
                    if (is_halt) begin
                        state_nxt = ST_DONE;
                    end else if (at_last_addr) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_nxt = ST_RECV;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_loading  = 1'b0;
        o_done     = 1'b0;
        o_overflow = 1'b0;
        case (state)
            ST_RECV:  o_loading  = 1'b1;
            ST_DONE:  o_done     = 1'b1;
            ST_ERROR: o_overflow = 1'b1;
            default: begin
                o_loading  = 1'b0;
                o_done     = 1'b0;
                o_overflow = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address counter
    // ------------------------------------------------------------------
    // o_wr_addr is captured alongside the packer's word register, so address
    // and data line up with the write strobe and hold steady through it. The
    // count steps on that same edge, so it already includes the word being
    // written while o_wr_en is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            word_count <= '0;
            o_wr_addr  <= '0;
        end else if (start_load) begin
            word_count <= '0;
        end else if (word_last) begin
            o_wr_addr  <= word_idx;
            word_count <= word_count + (ADDR_W + 1)'(1);
        end
    end

    assign o_wr_en      = word_vld;
    assign o_wr_data    = word_dat;
    assign o_word_count = word_count;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter LEN, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 11: instruction memory word address width (2048 words).
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: end-of-program marker.
REQ-004 i_clk  input  1: single clock; all logic on posedge.
REQ-005 i_rst  input  1: reset, synchronous, active-low.
REQ-006 i_start  input  1: one-cycle pulse that begins a program load.
REQ-007 i_rx_data  input  8: received byte.
REQ-008 i_rx_valid  input  1: i_rx_data valid this cycle; single-cycle strobe per byte.
REQ-009 o_wr_addr  output  ADDR_W: instruction memory word write address.
REQ-010 o_wr_data  output  LEN: instruction memory write data.
REQ-011 o_wr_en  output  1: instruction memory write strobe, one cycle per word.
REQ-012 o_loading  output  1: load in progress; holds fetch stage stalled.
REQ-013 o_done  output  1: program loaded, HALT_WORD written.
REQ-014 o_overflow  output  1: memory filled without HALT_WORD.
REQ-015 o_word_count  output  ADDR_W+1: number of words written in current load.

Function
REQ-016 FSM states: IDLE, RECV, DONE, ERROR.
REQ-017 IDLE: i_start -> RECV; word index, byte index and o_word_count cleared to 0; i_rx_valid ignored.
REQ-018 RECV: each i_rx_valid byte accepted; byte 0 to bits [31:24], byte 3 to bits [7:0] (big-endian).
REQ-019 The 4th accepted byte causes o_wr_en=1 on the next cycle, with o_wr_data = assembled word and o_wr_addr = current word index.
REQ-020 o_wr_en high exactly one cycle per word; o_wr_addr/o_wr_data stable during that cycle.
REQ-021 Byte index wraps 3->0 on the 4th byte; a byte arriving in the o_wr_en cycle is accepted as byte 0 of the next word, with no loss.
REQ-022 Word index increments by 1 after each write; o_word_count = words written so far.
REQ-023 Written word equal to HALT_WORD: it is still written; FSM -> DONE in the same cycle as the o_wr_en pulse.
REQ-024 Write to address 2^ADDR_W-1 of a word other than HALT_WORD: FSM -> ERROR; no further writes.
REQ-025 o_loading=1 exactly while in RECV.
REQ-026 o_done=1 exactly while in DONE; o_overflow=1 exactly while in ERROR.
REQ-027 DONE/ERROR: i_rx_valid ignored; i_start -> RECV with indices and o_word_count cleared.
REQ-028 i_start while in RECV: ignored; load continues.
REQ-029 i_start and i_rx_valid in the same IDLE cycle: the byte is discarded; the first byte is taken on a later cycle.
REQ-030 A partial word (1-3 bytes) is never written.

Reset
REQ-031 i_rst=0 at a posedge: FSM -> IDLE; o_wr_en, o_loading, o_done, o_overflow = 0; o_wr_addr, o_wr_data, o_word_count, byte index = 0.
REQ-032 Reset during RECV aborts the load immediately; no write pulse follows; partial word discarded.

Structure
REQ-033 FSM state encoding, HALT_WORD default and LEN/ADDR_W defaults are held in a shared MIPS package.
REQ-034 Byte-to-word assembly sits in one sub-module, byte_packer (byte-in strobe, word-out strobe); FSM and address counter stay in instruction_loader.

Verification
REQ-035 Reset then i_start; bytes 20,08,00,05 -> o_wr_en one cycle, addr 0, data 32'h20080005, o_word_count=1, o_loading=1.
REQ-036 Two words, then FF,FF,FF,FF -> writes at addr 0,1,2; third write data FFFFFFFF; o_done=1 and o_loading=0 from that cycle; later bytes produce no writes.
REQ-037 Back-to-back i_rx_valid for 8 cycles -> exactly 2 write pulses, addr 0 and 1; no byte lost.
REQ-038 ADDR_W=2; load 4 non-halt words -> 4 writes (addr 0..3), then o_overflow=1 and a 5th word is not written.
REQ-039 i_rst=0 after 2 bytes, release, i_start, 4 bytes -> single write at addr 0 containing only the post-reset bytes.
REQ-040 In DONE, pulse i_start; load 1 word -> write at addr 0, o_word_count=1, o_done=0.
